// File: rtl/lcd_pkg.sv
// Shared constants and state encodings for the HD44780 text driver.
package lcd_pkg;

    localparam logic [7:0] LCD_CMD_FUNC_8BIT = 8'h38;
    localparam logic [7:0] LCD_CMD_DISP_ON   = 8'h0C;
    localparam logic [7:0] LCD_CMD_CLEAR     = 8'h01;
    localparam logic [7:0] LCD_CMD_ENTRY_INC = 8'h06;
    localparam logic [7:0] LCD_CMD_DDRAM0    = 8'h80;

    localparam int INIT_LEN = 6;

    typedef enum logic [2:0] {
        ST_POWERUP,
        ST_INIT,
        ST_IDLE,
        ST_SET_ADDR,
        ST_WRITE_CHARS
    } lcd_state_e;

    typedef enum logic [1:0] {
        PH_IDLE,
        PH_SETUP,
        PH_PULSE,
        PH_WAIT
    } bus_phase_e;

    // Init ROM: function set is sent three times as the controller expects
    // from an unknown power-up state.
    function automatic logic [7:0] init_cmd(input logic [2:0] idx);
        case (idx)
            3'd0, 3'd1, 3'd2: init_cmd = LCD_CMD_FUNC_8BIT;
            3'd3:             init_cmd = LCD_CMD_DISP_ON;
            3'd4:             init_cmd = LCD_CMD_CLEAR;
            default:          init_cmd = LCD_CMD_ENTRY_INC;
        endcase
    endfunction

endpackage

// File: rtl/lcd_bus_writer.sv
// One write cycle on the LCD bus: setup cycle, enable pulse, post-write wait.
// Handshake: start is accepted only in a cycle where ready=1; rs/wr_byte/long_wait
// are captured with it. done is high during the final wait cycle of the write;
// ready returns on the following cycle.
module lcd_bus_writer
    import lcd_pkg::*;
#(
    parameter int EN_PULSE_CYCLES   = 25,
    parameter int CMD_WAIT_CYCLES   = 2500,
    parameter int CLEAR_WAIT_CYCLES = 82000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       start,
    input  logic       rs,
    input  logic [7:0] wr_byte,
    input  logic       long_wait,
    output logic       ready,
    output logic       done,
    output logic       lcd_e,
    output logic       lcd_rs,
    output logic [7:0] lcd_data
);

    localparam int CNT_MAX_A = (EN_PULSE_CYCLES > CMD_WAIT_CYCLES) ? EN_PULSE_CYCLES : CMD_WAIT_CYCLES;
    localparam int CNT_MAX   = (CNT_MAX_A > CLEAR_WAIT_CYCLES) ? CNT_MAX_A : CLEAR_WAIT_CYCLES;
    localparam int CNT_W     = $clog2(CNT_MAX + 1);

    bus_phase_e       phase_q, phase_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             rs_q, rs_d;
    logic [7:0]       data_q, data_d;
    logic             long_q, long_d;
    logic [CNT_W-1:0] wait_last;

    // Phase sequencing and counting for the current write.
    always_comb begin
        phase_d   = phase_q;
        cnt_d     = cnt_q;
        rs_d      = rs_q;
        data_d    = data_q;
        long_d    = long_q;
        done      = 1'b0;
        wait_last = long_q ? CNT_W'(CLEAR_WAIT_CYCLES - 1) : CNT_W'(CMD_WAIT_CYCLES - 1);
        case (phase_q)
            PH_IDLE: begin
                if (start) begin
                    rs_d    = rs;
                    data_d  = wr_byte;
                    long_d  = long_wait;
                    cnt_d   = '0;
                    phase_d = PH_SETUP;
                end
            end
            PH_SETUP: begin
                phase_d = PH_PULSE;
            end
            PH_PULSE: begin
                if (cnt_q == CNT_W'(EN_PULSE_CYCLES - 1)) begin
                    cnt_d   = '0;
                    phase_d = PH_WAIT;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            PH_WAIT: begin
                if (cnt_q == wait_last) begin
                    done    = 1'b1;
                    cnt_d   = '0;
                    phase_d = PH_IDLE;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            default: phase_d = PH_IDLE;
        endcase
    end

    // Register state; reset forces the strobe low on the next cycle.
    always_ff @(posedge clk) begin
        if (reset) begin
            phase_q <= PH_IDLE;
            cnt_q   <= '0;
            rs_q    <= 1'b0;
            data_q  <= 8'h00;
            long_q  <= 1'b0;
        end else begin
            phase_q <= phase_d;
            cnt_q   <= cnt_d;
            rs_q    <= rs_d;
            data_q  <= data_d;
            long_q  <= long_d;
        end
    end

    assign ready    = (phase_q == PH_IDLE);
    assign lcd_e    = (phase_q == PH_PULSE);
    assign lcd_rs   = rs_q;
    assign lcd_data = data_q;

endmodule

// File: rtl/lcd_text_driver.sv
// HD44780 16x1 text driver: power-up wait, init sequence, then full-line
// rewrites from a snapshot of the text frame on each refresh request.
module lcd_text_driver
    import lcd_pkg::*;
#(
    parameter int POWERUP_CYCLES    = 750000,
    parameter int EN_PULSE_CYCLES   = 25,
    parameter int CMD_WAIT_CYCLES   = 2500,
    parameter int CLEAR_WAIT_CYCLES = 82000
) (
    input  logic         clk,
    input  logic         reset,
    input  logic [127:0] text,
    input  logic         refresh,
    output logic         busy,
    output logic         init_done,
    output logic         lcd_rs,
    output logic         lcd_rw,
    output logic         lcd_e,
    output logic [7:0]   lcd_data
);

    localparam int PU_W = $clog2(POWERUP_CYCLES + 1);

    lcd_state_e       state_q, state_d;
    logic [PU_W-1:0]  pu_cnt_q, pu_cnt_d;
    logic [2:0]       init_idx_q, init_idx_d;
    logic [3:0]       char_idx_q, char_idx_d;
    logic [127:0]     snap_q, snap_d;
    logic             pending_q, pending_d;
    logic             init_done_q, init_done_d;
    logic             seq_end;

    logic             wr_start, wr_rs, wr_long, wr_ready, wr_done;
    logic [7:0]       wr_byte;

    // Sequencer: picks the next byte for the writer and handles refresh requests.
    always_comb begin
        state_d     = state_q;
        pu_cnt_d    = pu_cnt_q;
        init_idx_d  = init_idx_q;
        char_idx_d  = char_idx_q;
        snap_d      = snap_q;
        pending_d   = pending_q | (refresh && (state_q != ST_IDLE));
        init_done_d = init_done_q;
        seq_end     = 1'b0;
        wr_start    = 1'b0;
        wr_rs       = 1'b0;
        wr_byte     = 8'h00;
        wr_long     = 1'b0;
        case (state_q)
            ST_POWERUP: begin
                if (pu_cnt_q == PU_W'(POWERUP_CYCLES - 1)) begin
                    pu_cnt_d = '0;
                    state_d  = ST_INIT;
                end else begin
                    pu_cnt_d = pu_cnt_q + PU_W'(1);
                end
            end
            ST_INIT: begin
                wr_byte  = init_cmd(init_idx_q);
                wr_long  = (wr_byte == LCD_CMD_CLEAR);
                wr_start = wr_ready;
                if (wr_done) begin
                    if (init_idx_q == 3'(INIT_LEN - 1)) begin
                        init_idx_d  = 3'd0;
                        init_done_d = 1'b1;
                        seq_end     = 1'b1;
                    end else begin
                        init_idx_d = init_idx_q + 3'd1;
                    end
                end
            end
            ST_IDLE: begin
                if (refresh) begin
                    snap_d     = text;
                    char_idx_d = 4'd0;
                    state_d    = ST_SET_ADDR;
                end
            end
            ST_SET_ADDR: begin
                wr_byte  = LCD_CMD_DDRAM0;
                wr_start = wr_ready;
                if (wr_done) begin
                    char_idx_d = 4'd0;
                    state_d    = ST_WRITE_CHARS;
                end
            end
            ST_WRITE_CHARS: begin
                wr_rs    = 1'b1;
                wr_byte  = snap_q[8*char_idx_q +: 8];
                wr_start = wr_ready;
                if (wr_done) begin
                    if (char_idx_q == 4'd15) begin
                        seq_end = 1'b1;
                    end else begin
                        char_idx_d = char_idx_q + 4'd1;
                    end
                end
            end
            default: state_d = ST_POWERUP;
        endcase
        // A request that arrives on the return cycle merges with the pending one.
        if (seq_end) begin
            if (pending_q || refresh) begin
                pending_d  = 1'b0;
                snap_d     = text;
                char_idx_d = 4'd0;
                state_d    = ST_SET_ADDR;
            end else begin
                state_d = ST_IDLE;
            end
        end
    end

    // Sequencer registers; reset restarts from the power-up wait.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= ST_POWERUP;
            pu_cnt_q    <= '0;
            init_idx_q  <= 3'd0;
            char_idx_q  <= 4'd0;
            snap_q      <= '0;
            pending_q   <= 1'b0;
            init_done_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            pu_cnt_q    <= pu_cnt_d;
            init_idx_q  <= init_idx_d;
            char_idx_q  <= char_idx_d;
            snap_q      <= snap_d;
            pending_q   <= pending_d;
            init_done_q <= init_done_d;
        end
    end

    lcd_bus_writer #(
        .EN_PULSE_CYCLES  (EN_PULSE_CYCLES),
        .CMD_WAIT_CYCLES  (CMD_WAIT_CYCLES),
        .CLEAR_WAIT_CYCLES(CLEAR_WAIT_CYCLES)
    ) u_writer (
        .clk      (clk),
        .reset    (reset),
        .start    (wr_start),
        .rs       (wr_rs),
        .wr_byte  (wr_byte),
        .long_wait(wr_long),
        .ready    (wr_ready),
        .done     (wr_done),
        .lcd_e    (lcd_e),
        .lcd_rs   (lcd_rs),
        .lcd_data (lcd_data)
    );

    assign busy      = (state_q != ST_IDLE);
    assign init_done = init_done_q;
    assign lcd_rw    = 1'b0;

endmodule

// File: tb/tb_lcd_text_driver.sv
// Bench for lcd_text_driver with short timing parameters.
module tb_lcd_text_driver;

    logic         clk = 1'b0;
    logic         reset;
    logic [127:0] text;
    logic         refresh;
    logic         busy, init_done, lcd_rs, lcd_rw, lcd_e;
    logic [7:0]   lcd_data;

    int           checks = 0;
    int           errors = 0;
    int           cyc = 0;
    logic [8:0]   exp_q[$];
    int           fall_t[$];
    logic         e_prev = 1'b0;
    logic         mute = 1'b0;

    typedef struct {
        logic [127:0] text;
        logic [127:0] text_after;
        logic [127:0] shown;
    } vec_t;
    vec_t vecs[3];

    lcd_text_driver #(
        .POWERUP_CYCLES   (20),
        .EN_PULSE_CYCLES  (2),
        .CMD_WAIT_CYCLES  (5),
        .CLEAR_WAIT_CYCLES(10)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .text     (text),
        .refresh  (refresh),
        .busy     (busy),
        .init_done(init_done),
        .lcd_rs   (lcd_rs),
        .lcd_rw   (lcd_rw),
        .lcd_e    (lcd_e),
        .lcd_data (lcd_data)
    );

    // clock / cycle counter
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // bus monitor: each lcd_e fall is one logged write, checked against the queue
    always @(negedge clk) begin
        logic [8:0] exp;
        if (e_prev && !lcd_e && !mute) begin
            fall_t.push_back(cyc);
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL bus_write: unexpected write rs=%0b data=%02h", lcd_rs, lcd_data);
            end else begin
                exp = exp_q.pop_front();
                if ({lcd_rs, lcd_data} !== exp) begin
                    errors++;
                    $display("FAIL bus_write: got rs=%0b data=%02h expected rs=%0b data=%02h",
                             lcd_rs, lcd_data, exp[8], exp[7:0]);
                end
            end
        end
        e_prev = lcd_e;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [127:0] rev16(input logic [127:0] s);
        logic [127:0] r;
        for (int i = 0; i < 16; i++) r[8*i +: 8] = s[127-8*i -: 8];
        return r;
    endfunction

    task automatic push_init();
        exp_q.push_back({1'b0, 8'h38});
        exp_q.push_back({1'b0, 8'h38});
        exp_q.push_back({1'b0, 8'h38});
        exp_q.push_back({1'b0, 8'h0C});
        exp_q.push_back({1'b0, 8'h01});
        exp_q.push_back({1'b0, 8'h06});
    endtask

    task automatic push_frame(input logic [127:0] t);
        exp_q.push_back({1'b0, 8'h80});
        for (int i = 0; i < 16; i++) exp_q.push_back({1'b1, t[8*i +: 8]});
    endtask

    task automatic pulse_refresh();
        @(posedge clk); #1 refresh = 1'b1;
        @(posedge clk); #1 refresh = 1'b0;
    endtask

    task automatic wait_idle(input int bound, input string name);
        int n = 0;
        @(negedge clk);
        while (busy && n < bound) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (busy) begin
            errors++;
            $display("FAIL %s: busy still 1 after %0d cycles, expected 0", name, bound);
        end
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_lcd_e"},     128'(lcd_e),     128'(0));
        chk({tag, "_lcd_rs"},    128'(lcd_rs),    128'(0));
        chk({tag, "_lcd_rw"},    128'(lcd_rw),    128'(0));
        chk({tag, "_lcd_data"},  128'(lcd_data),  128'(0));
        chk({tag, "_busy"},      128'(busy),      128'(1));
        chk({tag, "_init_done"}, 128'(init_done), 128'(0));
    endtask

    initial begin
        logic [127:0] s, t1, t2;
        logic         any_e;
        int           g_clear, g_norm;

        vecs[0] = '{"HELLO, WORLD!...", "HELLO, WORLD!...", "HELLO, WORLD!..."};
        vecs[1] = '{"ABCDEFGHIJKLMNOP", "zzzzzzzzzzzzzzzz", "ABCDEFGHIJKLMNOP"};
        vecs[2] = '{"0123456789abcdef", "~~~~~~~~~~~~~~~~", "0123456789abcdef"};

        // test 1: reset, power-up and init sequence
        reset = 1'b1; refresh = 1'b0; text = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk_reset_outputs("reset");
        @(posedge clk); #1 reset = 1'b0;
        fall_t.delete();
        push_init();
        any_e = 1'b0;
        repeat (20) begin
            @(negedge clk);
            any_e = any_e | lcd_e;
        end
        chk("powerup_quiet", 128'(any_e), 128'(0));
        wait_idle(300, "init_idle");
        chk("init_done_after_init", 128'(init_done), 128'(1));
        chk("busy_after_init", 128'(busy), 128'(0));
        chk("init_log_drained", 128'(exp_q.size()), 128'(0));
        if (fall_t.size() >= 6) begin
            g_clear = fall_t[5] - fall_t[4];
            g_norm  = fall_t[4] - fall_t[3];
            chk("clear_gap_extra", 128'(g_clear - g_norm), 128'(5));
        end else begin
            checks++; errors++;
            $display("FAIL init_fall_count: got %0d expected 6", fall_t.size());
        end

        // tests 2/3: table frames, text changed the cycle after refresh
        for (int i = 0; i < 3; i++) begin
            text = rev16(vecs[i].text);
            @(posedge clk); #1 refresh = 1'b1;
            s = vecs[i].shown;
            exp_q.push_back({1'b0, 8'h80});
            for (int j = 0; j < 16; j++) exp_q.push_back({1'b1, s[127-8*j -: 8]});
            @(posedge clk); #1 refresh = 1'b0;
            text = rev16(vecs[i].text_after);
            @(negedge clk);
            chk("busy_after_refresh", 128'(busy), 128'(1));
            wait_idle(400, "frame_idle");
            chk("frame_drained", 128'(exp_q.size()), 128'(0));
            chk("frame_init_done", 128'(init_done), 128'(1));
        end

        // test 4: three requests during a frame -> exactly one extra frame
        t1 = {$urandom, $urandom, $urandom, $urandom};
        t2 = {$urandom, $urandom, $urandom, $urandom};
        text = t1;
        @(posedge clk); #1 refresh = 1'b1;
        push_frame(t1);
        @(posedge clk); #1 refresh = 1'b0;
        repeat (40) @(posedge clk);
        #1 text = t2;
        push_frame(t2);
        pulse_refresh();
        repeat (20) @(posedge clk);
        pulse_refresh();
        repeat (20) @(posedge clk);
        pulse_refresh();
        wait_idle(700, "merge_idle");
        repeat (60) @(negedge clk);
        chk("merge_drained", 128'(exp_q.size()), 128'(0));
        chk("merge_busy", 128'(busy), 128'(0));

        // test 5: refresh during INIT
        @(posedge clk); #1 reset = 1'b1; mute = 1'b1;
        repeat (2) @(posedge clk);
        #1 reset = 1'b0; mute = 1'b0;
        exp_q.delete();
        push_init();
        repeat (30) @(posedge clk);
        @(negedge clk);
        chk("in_init_busy", 128'(busy), 128'(1));
        chk("in_init_done", 128'(init_done), 128'(0));
        t1 = {$urandom, $urandom, $urandom, $urandom};
        text = t1;
        pulse_refresh();
        push_frame(t1);
        wait_idle(700, "init_refresh_idle");
        repeat (60) @(negedge clk);
        chk("init_refresh_drained", 128'(exp_q.size()), 128'(0));
        chk("init_refresh_done", 128'(init_done), 128'(1));

        // test 6: reset during the 7th data write while lcd_e=1
        t1 = {$urandom, $urandom, $urandom, $urandom};
        text = t1;
        pulse_refresh();
        push_frame(t1);
        begin
            int   n = 0;
            logic pe = 1'b0;
            logic hit = 1'b0;
            while (!hit && n < 400) begin
                @(negedge clk);
                hit = lcd_e && !pe && (exp_q.size() == 10);
                pe  = lcd_e;
                n++;
            end
            checks++;
            if (!hit) begin
                errors++;
                $display("FAIL reach_7th_write: got no strobe within %0d cycles, expected one", n);
            end
        end
        mute = 1'b1;
        reset = 1'b1;
        @(posedge clk); #1;
        chk_reset_outputs("midreset");
        exp_q.delete();
        @(posedge clk); #1 reset = 1'b0; mute = 1'b0;
        push_init();
        wait_idle(300, "reinit_idle");
        repeat (60) @(negedge clk);
        chk("reinit_drained", 128'(exp_q.size()), 128'(0));
        chk("reinit_done", 128'(init_done), 128'(1));
        chk("reinit_busy", 128'(busy), 128'(0));

        $display("End of test - %0d assertions evaluated, %0d failures", checks, errors);
        $finish;
    end

endmodule
